// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, issues fixed-latency imem reads and
// buffers returned instructions for decode behind a valid/ready FIFO.
module fetch_unit #(
  parameter int unsigned         PC_WIDTH    = 16,
  parameter int unsigned         INSTR_WIDTH = 16,
  parameter int unsigned         DEPTH       = 4,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   isbranchtaken,
  input  logic [PC_WIDTH-1:0]    branchpc,
  output logic                   imem_req,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic                   out_valid,
  output logic [INSTR_WIDTH-1:0] out_instr,
  output logic [PC_WIDTH-1:0]    out_pc,
  input  logic                   out_ready,
  output logic                   flush
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    REDIRECT
  } state_e;

  state_e                state_q, state_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic                  inflight_q, inflight_d;
  logic [PC_WIDTH-1:0]   ipc_q, ipc_d;
  logic [CW-1:0]         count_q, count_d;
  logic [AW-1:0]         wr_q, wr_d;
  logic [AW-1:0]         rd_q, rd_d;
  logic [INSTR_WIDTH-1:0] mem_instr_q [DEPTH];
  logic [PC_WIDTH-1:0]   mem_pc_q [DEPTH];

  logic [CW-1:0] occ;
  logic          issue;
  logic          push;
  logic          pop;

  // Occupancy counts the in-flight slot so a response always has room.
  assign occ   = count_q + CW'(inflight_q);
  assign issue = (state_q == RUN) && !isbranchtaken &&
                 (occ < CW'(DEPTH));
  assign push  = inflight_q && !isbranchtaken;
  assign pop   = out_valid && out_ready && !isbranchtaken;

  assign imem_req  = issue;
  assign imem_addr = pc_q;
  assign flush     = (state_q == REDIRECT);
  assign out_valid = (count_q != '0);
  assign out_instr = out_valid ? mem_instr_q[rd_q] : '0;
  assign out_pc    = out_valid ? mem_pc_q[rd_q] : '0;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BOOT:     state_d = RUN;
      RUN:      state_d = RUN;
      REDIRECT: state_d = RUN;
      default:  state_d = BOOT;
    endcase
    if (isbranchtaken && state_q != BOOT) begin
      state_d = REDIRECT;
    end
  end

  always_comb begin
    pc_d       = pc_q;
    inflight_d = issue;
    ipc_d      = ipc_q;
    count_d    = count_q;
    wr_d       = wr_q;
    rd_d       = rd_q;
    if (isbranchtaken && state_q != BOOT) begin
      pc_d       = branchpc;
      inflight_d = 1'b0;
      count_d    = '0;
      wr_d       = '0;
      rd_d       = '0;
    end else begin
      if (issue) begin
        pc_d  = pc_q + PC_WIDTH'(1);
        ipc_d = pc_q;
      end
      if (push) begin
        wr_d = wr_q + AW'(1);
      end
      if (pop) begin
        rd_d = rd_q + AW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      inflight_q <= 1'b0;
      ipc_q      <= '0;
      count_q    <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_instr_q[i] <= '0;
        mem_pc_q[i]    <= '0;
      end
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      ipc_q      <= ipc_d;
      count_q    <= count_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      if (push && !(state_q == BOOT && isbranchtaken)) begin
        mem_instr_q[wr_q] <= imem_rdata;
        mem_pc_q[wr_q]    <= ipc_q;
      end
    end
  end

endmodule
